alu_exec_unit_p: RTL and testbench

Parametrised successor to the 8-bit ALU/register-file execution core. It executes one register-to-register (or register-immediate) operation per start_cmd through a 4-state FSM. It also adds configurable data width and register count, 16 opcodes, carry-in ops, an immediate operand, N/V flags and a compare that does not write back. It sits between the command front end and the register file, and replaces the fixed 8-bit top for new CPU variants.

---
 rtl/alu_exec_unit_p.sv | 269 ++++++++++++++++++++++++++
 tb/tb_alu_exec_unit_p.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit_p.sv
// alu_exec_unit_p: parametrised ALU and register-file execution core.
// Runs one command per start_cmd through IDLE/READ/EXEC/WRITE.
module alu_exec_unit_p #(
  parameter  int DATA_W   = 8,
  parameter  int NUM_REGS = 8,
  localparam int RA_W     = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_cmd,
  input  logic [3:0]        op_in,
  input  logic [RA_W-1:0]   rd_in,
  input  logic [RA_W-1:0]   rs1_in,
  input  logic [RA_W-1:0]   rs2_in,
  input  logic              use_imm,
  input  logic [DATA_W-1:0] imm_in,
  output logic              busy,
  output logic              cmd_done,
  output logic              z_flag_out,
  output logic              c_flag_out,
  output logic              n_flag_out,
  output logic              v_flag_out,
  input  logic [RA_W-1:0]   dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int SH_W = $clog2(DATA_W);
  localparam int M    = DATA_W - 1;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SHL = 4'd5;
  localparam logic [3:0] OP_SHR = 4'd6;
  localparam logic [3:0] OP_MOV = 4'd7;
  localparam logic [3:0] OP_ADC = 4'd8;
  localparam logic [3:0] OP_SBB = 4'd9;
  localparam logic [3:0] OP_ROL = 4'd10;
  localparam logic [3:0] OP_ROR = 4'd11;
  localparam logic [3:0] OP_ASR = 4'd12;
  localparam logic [3:0] OP_CMP = 4'd13;
  localparam logic [3:0] OP_NOT = 4'd14;
  localparam logic [3:0] OP_NEG = 4'd15;

  typedef enum logic [1:0] {
    S_IDLE, S_READ, S_EXEC, S_WRITE
  } state_t;

  state_t state_q, state_d;

  logic [3:0]        op_q, op_d;
  logic [RA_W-1:0]   rd_q, rd_d;
  logic [RA_W-1:0]   rs1_q, rs1_d;
  logic [RA_W-1:0]   rs2_q, rs2_d;
  logic              use_imm_q, use_imm_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic              hz_q, hz_d, hc_q, hc_d;
  logic              hn_q, hn_d, hv_q, hv_d;
  logic              z_q, z_d, c_q, c_d;
  logic              n_q, n_d, v_q, v_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];

  logic [SH_W-1:0]   sh;
  logic [SH_W:0]     inv_sh;
  logic              cin;
  logic [DATA_W:0]   add_w, sub_w, shl_w, shr_w, asr_w;
  logic [DATA_W-1:0] rol_r, ror_r;
  logic [DATA_W-1:0] alu_res;
  logic              alu_c, alu_v;

  assign sh     = b_q[SH_W-1:0];
  assign inv_sh = (SH_W+1)'(DATA_W) - {1'b0, sh};

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state: fixed walk once a command is accepted
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start_cmd) state_d = S_READ;
      S_READ:  state_d = S_EXEC;
      S_EXEC:  state_d = S_WRITE;
      S_WRITE: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state and registered flags
  always_comb begin
    busy       = (state_q != S_IDLE);
    cmd_done   = done_q;
    z_flag_out = z_q;
    c_flag_out = c_q;
    n_flag_out = n_q;
    v_flag_out = v_q;
    dbg_data   = regs_q[dbg_addr];
  end

  // ALU: result, carry and overflow from latched operands
  always_comb begin
    cin   = c_q & ((op_q == OP_ADC) | (op_q == OP_SBB));
    add_w = {1'b0, a_q} + {1'b0, b_q} + {{DATA_W{1'b0}}, cin};
    sub_w = {1'b0, a_q} - {1'b0, b_q} - {{DATA_W{1'b0}}, cin};
    shl_w = {1'b0, a_q} << sh;
    shr_w = {a_q, 1'b0} >> sh;
    asr_w = $signed({a_q, 1'b0}) >>> sh;
    rol_r = (a_q << sh) | (a_q >> inv_sh);
    ror_r = (a_q >> sh) | (a_q << inv_sh);
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    unique case (op_q)
      OP_ADD, OP_ADC: begin
        alu_res = add_w[M:0];
        alu_c   = add_w[DATA_W];
        alu_v   = (a_q[M] == b_q[M]) & (alu_res[M] != a_q[M]);
      end
      OP_SUB, OP_SBB, OP_CMP: begin
        alu_res = sub_w[M:0];
        alu_c   = sub_w[DATA_W];
        alu_v   = (a_q[M] != b_q[M]) & (alu_res[M] != a_q[M]);
      end
      OP_AND: alu_res = a_q & b_q;
      OP_OR:  alu_res = a_q | b_q;
      OP_XOR: alu_res = a_q ^ b_q;
      OP_MOV: alu_res = b_q;
      OP_NOT: alu_res = ~a_q;
      OP_SHL: begin
        alu_res = shl_w[M:0];
        alu_c   = shl_w[DATA_W];
      end
      OP_SHR: begin
        alu_res = shr_w[DATA_W:1];
        alu_c   = shr_w[0];
      end
      OP_ASR: begin
        alu_res = asr_w[DATA_W:1];
        alu_c   = asr_w[0];
      end
      OP_ROL: begin
        alu_res = rol_r;
        alu_c   = rol_r[0];
      end
      OP_ROR: begin
        alu_res = ror_r;
        alu_c   = ror_r[M];
      end
      OP_NEG: begin
        alu_res = '0 - a_q;
        alu_c   = |a_q;
        alu_v   = a_q[M] & alu_res[M];
      end
    endcase
    // A zero shift/rotate leaves A untouched and shifts nothing out
    if (sh == '0 && (op_q == OP_SHL || op_q == OP_SHR ||
        op_q == OP_ASR || op_q == OP_ROL || op_q == OP_ROR))
      alu_c = 1'b0;
  end

  // Datapath next values per FSM phase
  always_comb begin
    op_d      = op_q;
    rd_d      = rd_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    use_imm_d = use_imm_q;
    imm_d     = imm_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    hz_d      = hz_q;
    hc_d      = hc_q;
    hn_d      = hn_q;
    hv_d      = hv_q;
    z_d       = z_q;
    c_d       = c_q;
    n_d       = n_q;
    v_d       = v_q;
    done_d    = 1'b0;
    regs_d    = regs_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_cmd) begin
          op_d      = op_in;
          rd_d      = rd_in;
          rs1_d     = rs1_in;
          rs2_d     = rs2_in;
          use_imm_d = use_imm;
          imm_d     = imm_in;
        end
      end
      S_READ: begin
        a_d = regs_q[rs1_q];
        b_d = use_imm_q ? imm_q : regs_q[rs2_q];
      end
      S_EXEC: begin
        res_d = alu_res;
        hz_d  = (alu_res == '0);
        hc_d  = alu_c;
        hn_d  = alu_res[M];
        hv_d  = alu_v;
      end
      S_WRITE: begin
        if (op_q != OP_CMP) regs_d[rd_q] = res_q;
        z_d    = hz_q;
        c_d    = hc_q;
        n_d    = hn_q;
        v_d    = hv_q;
        done_d = 1'b1;
      end
    endcase
  end

  // Datapath, flag and register-file storage
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q      <= '0;
      rd_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      use_imm_q <= 1'b0;
      imm_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      hz_q      <= 1'b0;
      hc_q      <= 1'b0;
      hn_q      <= 1'b0;
      hv_q      <= 1'b0;
      z_q       <= 1'b0;
      c_q       <= 1'b0;
      n_q       <= 1'b0;
      v_q       <= 1'b0;
      done_q    <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      op_q      <= op_d;
      rd_q      <= rd_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      use_imm_q <= use_imm_d;
      imm_q     <= imm_d;
      a_q       <= a_d;
      b_q       <= b_d;
      res_q     <= res_d;
      hz_q      <= hz_d;
      hc_q      <= hc_d;
      hn_q      <= hn_d;
      hv_q      <= hv_d;
      z_q       <= z_d;
      c_q       <= c_d;
      n_q       <= n_d;
      v_q       <= v_d;
      done_q    <= done_d;
      regs_q    <= regs_d;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit_p.sv
// tb_alu_exec_unit_p: directed checks of alu_exec_unit_p
// at 8-bit/8-reg and 16-bit/16-reg configurations.
module tb_alu_exec_unit_p;

  localparam logic [3:0] ADD = 4'd0,  SUB = 4'd1,  MOV = 4'd7;
  localparam logic [3:0] ADC = 4'd8,  ROL = 4'd10, ROR = 4'd11;
  localparam logic [3:0] ASR = 4'd12, CMP = 4'd13, NEG = 4'd15;
  localparam logic [3:0] SHL = 4'd5,  SHR = 4'd6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       start8 = 0, ui8 = 0;
  logic [3:0] op8 = 0;
  logic [2:0] rd8 = 0, rs18 = 0, rs28 = 0, dbga8 = 0;
  logic [7:0] imm8 = 0, dbgd8;
  logic       busy8, done8, z8, c8, n8, v8;

  logic        start16 = 0, ui16 = 0;
  logic [3:0]  op16 = 0;
  logic [3:0]  rd16 = 0, rs116 = 0, rs216 = 0, dbga16 = 0;
  logic [15:0] imm16 = 0, dbgd16;
  logic        busy16, done16, z16, c16, n16, v16;

  int n_chk = 0;
  int n_fail = 0;

  alu_exec_unit_p #(.DATA_W(8), .NUM_REGS(8)) dut8 (
    .clk(clk), .rst(rst), .start_cmd(start8), .op_in(op8),
    .rd_in(rd8), .rs1_in(rs18), .rs2_in(rs28), .use_imm(ui8),
    .imm_in(imm8), .busy(busy8), .cmd_done(done8),
    .z_flag_out(z8), .c_flag_out(c8), .n_flag_out(n8),
    .v_flag_out(v8), .dbg_addr(dbga8), .dbg_data(dbgd8)
  );

  alu_exec_unit_p #(.DATA_W(16), .NUM_REGS(16)) dut16 (
    .clk(clk), .rst(rst), .start_cmd(start16), .op_in(op16),
    .rd_in(rd16), .rs1_in(rs116), .rs2_in(rs216), .use_imm(ui16),
    .imm_in(imm16), .busy(busy16), .cmd_done(done16),
    .z_flag_out(z16), .c_flag_out(c16), .n_flag_out(n16),
    .v_flag_out(v16), .dbg_addr(dbga16), .dbg_data(dbgd16)
  );

  task automatic rdreg8(input logic [2:0] a, output logic [7:0] d);
    dbga8 = a;
    #1;
    d = dbgd8;
  endtask

  task automatic rdreg16(input logic [3:0] a, output logic [15:0] d);
    dbga16 = a;
    #1;
    d = dbgd16;
  endtask

  // Issue one command on dut8 and check busy/cmd_done timing
  task automatic cmd8(input logic [3:0] op, input logic [2:0] rd,
                      input logic [2:0] rs1, input logic [2:0] rs2,
                      input logic ui, input logic [7:0] imm);
    logic [1:0] exp;
    @(negedge clk);
    op8 = op; rd8 = rd; rs18 = rs1; rs28 = rs2;
    ui8 = ui; imm8 = imm; start8 = 1;
    @(posedge clk); #1;
    start8 = 0;
    op8 = ~op; rd8 = ~rd; rs18 = ~rs1; rs28 = ~rs2;
    ui8 = ~ui; imm8 = ~imm;
    n_chk++;
    if ({busy8, done8} !== 2'b10) begin
      n_fail++;
      $display("FAIL lat op%0d k0: busy,done got %b want 10",
               op, {busy8, done8});
    end
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      exp = (k < 3) ? 2'b10 : 2'b01;
      n_chk++;
      if ({busy8, done8} !== exp) begin
        n_fail++;
        $display("FAIL lat op%0d k%0d: busy,done got %b want %b",
                 op, k, {busy8, done8}, exp);
      end
    end
  endtask

  task automatic cmd16(input logic [3:0] op, input logic [3:0] rd,
                       input logic [3:0] rs1, input logic [3:0] rs2,
                       input logic ui, input logic [15:0] imm);
    @(negedge clk);
    op16 = op; rd16 = rd; rs116 = rs1; rs216 = rs2;
    ui16 = ui; imm16 = imm; start16 = 1;
    @(posedge clk); #1;
    start16 = 0;
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if ({busy16, done16} !== 2'b01) begin
      n_fail++;
      $display("FAIL lat16 op%0d: busy,done got %b want 01",
               op, {busy16, done16});
    end
  endtask

  task automatic test_reset;
    logic [7:0] d;
    #1;
    n_chk++;
    if ({busy8, done8, z8, c8, n8, v8} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_outs: got %b want 000000",
               {busy8, done8, z8, c8, n8, v8});
    end
    for (int i = 0; i < 8; i++) begin
      rdreg8(i[2:0], d);
      n_chk++;
      if (d !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_r%0d: got %h want 00", i, d);
      end
    end
    @(negedge clk);
    rst = 0;
    cmd8(MOV, 3'd1, 3'd0, 3'd0, 1'b1, 8'h10);
    cmd8(MOV, 3'd2, 3'd0, 3'd0, 1'b1, 8'h80);
    n_chk++;
    if (n8 !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_n: got %b want 1", n8);
    end
    @(negedge clk);
    op8 = ADD; rd8 = 3'd4; rs18 = 3'd1; rs28 = 3'd1;
    ui8 = 0; start8 = 1;
    @(posedge clk); #1;
    start8 = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 1;
    @(posedge clk); #1;
    n_chk++;
    if ({busy8, done8, z8, c8, n8, v8} !== 6'b0) begin
      n_fail++;
      $display("FAIL midreset_outs: got %b want 000000",
               {busy8, done8, z8, c8, n8, v8});
    end
    for (int i = 0; i < 8; i++) begin
      rdreg8(i[2:0], d);
      n_chk++;
      if (d !== 8'h00) begin
        n_fail++;
        $display("FAIL midreset_r%0d: got %h want 00", i, d);
      end
    end
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      n_chk++;
      if ({busy8, done8} !== 2'b00) begin
        n_fail++;
        $display("FAIL midreset_idle%0d: busy,done got %b want 00",
                 i, {busy8, done8});
      end
    end
  endtask

  task automatic test_add;
    logic [7:0] d;
    cmd8(MOV, 3'd1, 3'd0, 3'd0, 1'b1, 8'h10);
    cmd8(MOV, 3'd2, 3'd0, 3'd0, 1'b1, 8'h0A);
    cmd8(MOV, 3'd3, 3'd0, 3'd0, 1'b1, 8'hFF);
    cmd8(ADD, 3'd4, 3'd1, 3'd2, 1'b0, 8'h00);
    n_chk++;
    if ({z8, c8, n8, v8} !== 4'b0000) begin
      n_fail++;
      $display("FAIL add_flags: zcnv got %b want 0000", {z8, c8, n8, v8});
    end
    rdreg8(3'd4, d);
    n_chk++;
    if (d !== 8'h1A) begin
      n_fail++;
      $display("FAIL add_r4: got %h want 1a", d);
    end
    cmd8(ADD, 3'd7, 3'd3, 3'd2, 1'b0, 8'h00);
    n_chk++;
    if ({z8, c8, n8, v8} !== 4'b0100) begin
      n_fail++;
      $display("FAIL addc_flags: zcnv got %b want 0100", {z8, c8, n8, v8});
    end
    rdreg8(3'd7, d);
    n_chk++;
    if (d !== 8'h09) begin
      n_fail++;
      $display("FAIL addc_r7: got %h want 09", d);
    end
    cmd8(ADC, 3'd6, 3'd1, 3'd2, 1'b0, 8'h00);
    rdreg8(3'd6, d);
    n_chk++;
    if (d !== 8'h1B) begin
      n_fail++;
      $display("FAIL adc_r6: got %h want 1b", d);
    end
    n_chk++;
    if ({z8, c8, n8, v8} !== 4'b0000) begin
      n_fail++;
      $display("FAIL adc_flags: zcnv got %b want 0000", {z8, c8, n8, v8});
    end
  endtask

  task automatic test_cmp;
    logic [7:0] d;
    logic [7:0] m [8];
    m = '{8'h00, 8'h10, 8'h0A, 8'hFF, 8'h1A, 8'h10, 8'h1B, 8'h09};
    cmd8(MOV, 3'd5, 3'd0, 3'd0, 1'b1, 8'h10);
    cmd8(CMP, 3'd5, 3'd5, 3'd1, 1'b0, 8'h00);
    n_chk++;
    if ({z8, c8, n8, v8} !== 4'b1000) begin
      n_fail++;
      $display("FAIL cmp_flags: zcnv got %b want 1000", {z8, c8, n8, v8});
    end
    for (int i = 0; i < 8; i++) begin
      rdreg8(i[2:0], d);
      n_chk++;
      if (d !== m[i]) begin
        n_fail++;
        $display("FAIL cmp_r%0d: got %h want %h", i, d, m[i]);
      end
    end
    cmd8(SUB, 3'd6, 3'd2, 3'd1, 1'b0, 8'h00);
    n_chk++;
    if ({z8, c8, n8, v8} !== 4'b0110) begin
      n_fail++;
      $display("FAIL sub_flags: zcnv got %b want 0110", {z8, c8, n8, v8});
    end
    rdreg8(3'd6, d);
    n_chk++;
    if (d !== 8'hFA) begin
      n_fail++;
      $display("FAIL sub_r6: got %h want fa", d);
    end
  endtask

  task automatic test_overflow;
    logic [7:0] d;
    cmd8(MOV, 3'd3, 3'd0, 3'd0, 1'b1, 8'h7F);
    cmd8(ADD, 3'd4, 3'd3, 3'd0, 1'b1, 8'h01);
    n_chk++;
    if ({z8, c8, n8, v8} !== 4'b0011) begin
      n_fail++;
      $display("FAIL ovf_flags: zcnv got %b want 0011", {z8, c8, n8, v8});
    end
    rdreg8(3'd4, d);
    n_chk++;
    if (d !== 8'h80) begin
      n_fail++;
      $display("FAIL ovf_r4: got %h want 80", d);
    end
    cmd8(MOV, 3'd5, 3'd0, 3'd0, 1'b1, 8'h80);
    cmd8(NEG, 3'd6, 3'd5, 3'd0, 1'b0, 8'h00);
    n_chk++;
    if ({z8, c8, n8, v8} !== 4'b0111) begin
      n_fail++;
      $display("FAIL neg_flags: zcnv got %b want 0111", {z8, c8, n8, v8});
    end
    rdreg8(3'd6, d);
    n_chk++;
    if (d !== 8'h80) begin
      n_fail++;
      $display("FAIL neg_r6: got %h want 80", d);
    end
  endtask

  task automatic test_shift;
    logic [7:0] d;
    cmd8(MOV, 3'd1, 3'd0, 3'd0, 1'b1, 8'h81);
    cmd8(ROL, 3'd2, 3'd1, 3'd0, 1'b1, 8'h01);
    rdreg8(3'd2, d);
    n_chk++;
    if (d !== 8'h03 || c8 !== 1'b1) begin
      n_fail++;
      $display("FAIL rol: got %h c%b want 03 c1", d, c8);
    end
    cmd8(SHL, 3'd4, 3'd1, 3'd0, 1'b1, 8'h00);
    rdreg8(3'd4, d);
    n_chk++;
    if (d !== 8'h81 || {z8, c8, n8, v8} !== 4'b0010) begin
      n_fail++;
      $display("FAIL shl0: got %h zcnv %b want 81 0010",
               d, {z8, c8, n8, v8});
    end
    cmd8(ROR, 3'd3, 3'd1, 3'd0, 1'b1, 8'h01);
    rdreg8(3'd3, d);
    n_chk++;
    if (d !== 8'hC0 || {z8, c8, n8, v8} !== 4'b0110) begin
      n_fail++;
      $display("FAIL ror: got %h zcnv %b want c0 0110",
               d, {z8, c8, n8, v8});
    end
    cmd8(ASR, 3'd3, 3'd5, 3'd0, 1'b1, 8'h03);
    rdreg8(3'd3, d);
    n_chk++;
    if (d !== 8'hF0 || {z8, c8, n8, v8} !== 4'b0010) begin
      n_fail++;
      $display("FAIL asr: got %h zcnv %b want f0 0010",
               d, {z8, c8, n8, v8});
    end
    cmd8(SHL, 3'd4, 3'd1, 3'd0, 1'b1, 8'h01);
    rdreg8(3'd4, d);
    n_chk++;
    if (d !== 8'h02 || c8 !== 1'b1) begin
      n_fail++;
      $display("FAIL shl1: got %h c%b want 02 c1", d, c8);
    end
    cmd8(SHR, 3'd4, 3'd1, 3'd0, 1'b1, 8'h08);
    rdreg8(3'd4, d);
    n_chk++;
    if (d !== 8'h81 || c8 !== 1'b0) begin
      n_fail++;
      $display("FAIL shr8: got %h c%b want 81 c0", d, c8);
    end
  endtask

  task automatic test_back_to_back;
    logic [11:0] seen;
    logic [7:0]  d;
    int          cnt;
    seen = '0;
    cnt  = 0;
    @(negedge clk);
    op8 = MOV; rd8 = 3'd1; ui8 = 1; imm8 = 8'h11; start8 = 1;
    @(posedge clk); #1;
    op8 = ADD; rd8 = 3'd2; rs18 = 3'd1; ui8 = 1; imm8 = 8'h11;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      if (i == 4) start8 = 0;
      seen[i-1] = done8;
      if (done8) cnt++;
    end
    n_chk++;
    if (cnt != 2) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d want 2", cnt);
    end
    n_chk++;
    if (seen !== 12'h044) begin
      n_fail++;
      $display("FAIL b2b_timing: got %h want 044", seen);
    end
    rdreg8(3'd2, d);
    n_chk++;
    if (d !== 8'h22) begin
      n_fail++;
      $display("FAIL b2b_r2: got %h want 22", d);
    end
  endtask

  task automatic test_wide;
    logic [15:0] d;
    cmd16(MOV, 4'd3, 4'd0, 4'd0, 1'b1, 16'hFFFF);
    cmd16(MOV, 4'd2, 4'd0, 4'd0, 1'b1, 16'h000A);
    cmd16(ADD, 4'd15, 4'd3, 4'd2, 1'b0, 16'h0000);
    n_chk++;
    if ({z16, c16, n16, v16} !== 4'b0100) begin
      n_fail++;
      $display("FAIL w_flags: zcnv got %b want 0100",
               {z16, c16, n16, v16});
    end
    rdreg16(4'd15, d);
    n_chk++;
    if (d !== 16'h0009) begin
      n_fail++;
      $display("FAIL w_r15: got %h want 0009", d);
    end
    rdreg16(4'd14, d);
    n_chk++;
    if (d !== 16'h0000) begin
      n_fail++;
      $display("FAIL w_r14: got %h want 0000", d);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    test_reset;
    test_add;
    test_cmp;
    test_overflow;
    test_shift;
    test_back_to_back;
    test_wide;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
